pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage of the pipelined CPU.
- Holds the fetch address and advances it by one instruction per accepted fetch.
- Applies exception, branch and jump redirects in fixed priority, and honours hazard stalls.
- Run control is a small IDLE/RUN/HALT state machine; an accepted-fetch counter supports performance checks.

Parameters:
XLEN, 32, width of PC and target addresses.
INSTR_BYTES, 4, PC increment per instruction; power of two, at least 1.
RESET_VEC, 32'h0000_0000, PC value after reset.
TRAP_VEC, 32'h0000_0080, PC loaded on exception.
CNT_W, 32, width of accepted-fetch counter.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
start_i  input  1  run enable; IDLE->RUN; low in RUN freezes PC
halt_i  input  1  request HALT
stall_i  input  1  hazard stall; holds PC
exc_i  input  1  exception redirect to TRAP_VEC
br_taken_i  input  1  branch redirect valid
br_target_i  input  XLEN  branch target
jmp_i  input  1  jump redirect valid
jmp_target_i  input  XLEN  jump target
fetch_ready_i  input  1  instruction memory accepts pc_o this cycle
pc_o  output  XLEN  current fetch address
pc_valid_o  output  1  pc_o is a valid fetch request
fetch_cnt_o  output  CNT_W  number of accepted fetches
state_o  output  2  00 IDLE, 01 RUN, 10 HALT

Behaviour:
Reset:
- Reset is rst_i, asynchronous, active-low; clock is clk_i.
- While rst_i is low: pc_o=RESET_VEC, pc_valid_o=0, fetch_cnt_o=0, state=IDLE.
- Reset asserted mid-operation aborts everything immediately; no pending state survives.

pc_valid_o is combinational: 1 iff state=RUN and start_i=1.

A fetch is accepted when pc_valid_o=1, fetch_ready_i=1 and stall_i=0. On acceptance, fetch_cnt_o increments. fetch_cnt_o wraps modulo 2^CNT_W.

State IDLE:
- pc_o holds.
- start_i=1 -> RUN next cycle; no fetch occurs in the transition cycle.
- exc_i=1 -> pc_o<=TRAP_VEC and state<=RUN, without waiting for start_i.

State RUN: next-PC selection, evaluated every cycle, highest priority first:
- exc_i -> TRAP_VEC.
- br_taken_i -> br_target_i.
- jmp_i -> jmp_target_i.
- start_i=0 or stall_i=1 -> hold.
- accepted fetch -> pc_o+INSTR_BYTES, wrapping modulo 2^XLEN (all-ones-region PC wraps to 0).
- otherwise (fetch_ready_i=0) -> hold.

Redirect rules:
- Redirects override stall_i, start_i=0 and fetch_ready_i=0.
- A redirect is visible on pc_o exactly one cycle after it is asserted.
- In a redirect cycle a fetch may still be accepted at the old pc_o (it counts); the increment is discarded.

halt_i in RUN:
- state<=HALT next cycle and pc_o holds.
- If a redirect is asserted in the same cycle, it is still applied to pc_o.
- exc_i has priority over halt_i: state stays RUN.

State HALT:
- pc_valid_o=0 and pc_o holds.
- exc_i -> TRAP_VEC and RUN.
- All other inputs are ignored; only reset or exc_i leaves HALT.

Redirect targets with nonzero low log2(INSTR_BYTES) bits are handled per the optional feature.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: adds output misalign_o (1 bit, reset 0). A branch or jump redirect with misaligned target loads TRAP_VEC instead of the target, and pulses misalign_o high for exactly one cycle, the cycle pc_o shows TRAP_VEC.
- Undefined: no misalign_o port; the low log2(INSTR_BYTES) bits of redirect targets are forced to zero on load.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants PC_IDLE=2'b00, PC_RUN=2'b01, PC_HALT=2'b10;
  - default RESET_VEC and TRAP_VEC constants;
  - next-PC select encoding: SEL_HOLD, SEL_INC, SEL_EXC, SEL_BR, SEL_JMP.
- One sub-module, pc_next_sel: combinational priority encoder producing the select code and next-PC value. State register, counter and PC register stay in pc_gen.

Test Plan:
- Reset then start: rst_i low 3 cycles; start_i=1, fetch_ready_i=1 -> IDLE for the cycle after reset release, then pc_o sequence 0,4,8,12; fetch_cnt_o=3 after four RUN cycles.
- Stall and backpressure: stall_i=1 at pc_o=8 for 2 cycles, then fetch_ready_i=0 for 1 cycle -> pc_o stays 8 for 3 cycles, fetch_cnt_o unchanged, then 12.
- Priority: exc_i, br_taken_i (target 0x100) and jmp_i (target 0x200) together with stall_i=1 -> pc_o=0x80 next cycle; br+jmp only -> 0x100; jmp only -> 0x200.
- Wrap: XLEN=8, pc_o=8'hFC, accepted fetch -> pc_o=8'h00.
- Halt/exception: halt_i in RUN -> state HALT, pc_valid_o=0, start_i toggling has no effect; exc_i -> RUN at 0x80.
- Alignment (both builds): br_target_i=0x102; PC_ALIGN_CHECK_EN defined -> pc_o=0x80 and misalign_o one-cycle pulse; undefined -> pc_o=0x100.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch-stage PC generator
//
// Purpose: run-control state encoding, next-PC select codes and default
//          reset/trap vectors used by pc_gen and pc_next_sel.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_IDLE = 2'b00,
    PC_RUN  = 2'b01,
    PC_HALT = 2'b10
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_INC  = 3'd1,
    SEL_EXC  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_JMP  = 3'd4
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

  // True for selects that load a new address rather than hold or step.
  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == SEL_EXC) || (sel == SEL_BR) || (sel == SEL_JMP);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority encoder
//
// Purpose: picks the next fetch address from exception, branch, jump,
//          sequential step or hold, highest priority first.
// Optional: PC_ALIGN_CHECK_EN adds misalign_o; misaligned branch/jump
//           targets then load TRAP_VEC. Without it the low target bits
//           are cleared.
// Ports:
//   state_i          current run-control state
//   accept_i         a fetch is accepted at pc_i this cycle
//   exc_i            exception redirect
//   br_taken_i/br_target_i    branch redirect and target
//   jmp_i/jmp_target_i        jump redirect and target
//   pc_i             current fetch address
//   sel_o            chosen select code
//   pc_next_o        next fetch address for that select
//   misalign_o       (PC_ALIGN_CHECK_EN) redirect target was misaligned
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC)
) (
  input  pc_state_e       state_i,
  input  logic            accept_i,
  input  logic            exc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic [XLEN-1:0] pc_i,
`ifdef PC_ALIGN_CHECK_EN
  output logic            misalign_o,
`endif
  output pc_sel_e         sel_o,
  output logic [XLEN-1:0] pc_next_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] tgt;

  // Outside RUN only an exception can move the PC; stall/start gating is
  // already folded into accept_i, so "no accept" simply means hold.
  always_comb begin
    sel_o = SEL_HOLD;
    if (exc_i) begin
      sel_o = SEL_EXC;
    end else if (state_i == PC_RUN) begin
      if (br_taken_i)    sel_o = SEL_BR;
      else if (jmp_i)    sel_o = SEL_JMP;
      else if (accept_i) sel_o = SEL_INC;
    end
  end

  always_comb begin
    tgt       = (sel_o == SEL_JMP) ? jmp_target_i : br_target_i;
    pc_next_o = pc_i;
`ifdef PC_ALIGN_CHECK_EN
    misalign_o = 1'b0;
`endif
    case (sel_o)
      SEL_INC: pc_next_o = pc_i + PC_STEP;
      SEL_EXC: pc_next_o = TRAP_VEC;
      SEL_BR, SEL_JMP: begin
`ifdef PC_ALIGN_CHECK_EN
        if ((tgt & ALIGN_MASK) != '0) begin
          pc_next_o  = TRAP_VEC;
          misalign_o = 1'b1;
        end else begin
          pc_next_o = tgt;
        end
`else
        pc_next_o = tgt & ~ALIGN_MASK;
`endif
      end
      default: pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with run control
//
// Purpose: holds the fetch address, steps it per accepted fetch, applies
//          exception/branch/jump redirects, and runs an IDLE/RUN/HALT FSM
//          plus an accepted-fetch counter.
// Optional: PC_ALIGN_CHECK_EN adds misalign_o (one-cycle pulse while pc_o
//           shows TRAP_VEC after a misaligned branch/jump target).
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset
//   start_i          run enable (IDLE->RUN; low in RUN freezes PC)
//   halt_i           request HALT
//   stall_i          hazard stall
//   exc_i            exception redirect to TRAP_VEC
//   br_taken_i/br_target_i, jmp_i/jmp_target_i   redirects
//   fetch_ready_i    instruction memory accepts pc_o
//   pc_o, pc_valid_o fetch request
//   fetch_cnt_o      accepted fetches, wraps
//   state_o          00 IDLE, 01 RUN, 10 HALT
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             jmp_i,
  input  logic [XLEN-1:0]  jmp_target_i,
  input  logic             fetch_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misalign_o,
`endif
  output logic [1:0]       state_o
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, pc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pc_sel_e          sel;
  logic             accept;

  assign pc_valid_o = (state_q == PC_RUN) && start_i;
  assign accept     = pc_valid_o && fetch_ready_i && !stall_i;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_d, misalign_q;
`endif

  pc_next_sel #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES),
    .TRAP_VEC    (TRAP_VEC)
  ) u_next_sel (
    .state_i      (state_q),
    .accept_i     (accept),
    .exc_i        (exc_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .pc_i         (pc_q),
`ifdef PC_ALIGN_CHECK_EN
    .misalign_o   (misalign_d),
`endif
    .sel_o        (sel),
    .pc_next_o    (pc_next)
  );

  // Exception always wins over halt, so it both leaves HALT/IDLE and keeps
  // RUN from entering HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_IDLE: if (exc_i || start_i)  state_d = PC_RUN;
      PC_RUN:  if (!exc_i && halt_i)  state_d = PC_HALT;
      PC_HALT: if (exc_i)             state_d = PC_RUN;
      default:                        state_d = PC_IDLE;
    endcase
  end

  // A halting cycle freezes the PC unless a redirect lands; a fetch taken
  // in that cycle still counts.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept);
    pc_d  = pc_next;
    if ((state_q == PC_RUN) && halt_i && !is_redirect(sel)) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= PC_IDLE;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`endif

  assign pc_o        = pc_q;
  assign fetch_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule
